q_sys_pll_reset_sequencer: RTL
==============================

// Module: q_sys_pll_reset_sequencer
// PURPOSE
//  Owns the request side of the PLL status interconnect: drives the pll_powerdown and mcgb_rst
//  lines into the interconnect and consumes pll_locked coming back from it.
//  Sequences power-down, lock acquisition, lock qualification and master-CGB reset release.
//  Reports a single qualified pll_ready to downstream TX reset logic.
//  Counts loss-of-lock events and flags lock timeouts.
// PARAMETERS
//  PWRDN_CYCLES        1000    cycles pll_powerdown is held per power-down phase (>=1)
//  LOCK_STABLE_CYCLES  500     consecutive synced-lock cycles needed to qualify lock (>=1)
//  LOCK_TIMEOUT_CYCLES 100000  max cycles in WAIT_LOCK before fault (> LOCK_STABLE_CYCLES)
//  MCGB_RST_CYCLES     100     cycles mcgb_rst is held after lock qualifies (>=1)
//  CNT_W               20      width of the shared phase counter; must hold every count above
// PORTS
//  clock          in   1  system clock
//  reset          in   1  synchronous, active-high reset
//  pll_locked     in   1  raw PLL lock from interconnect; asynchronous, 2-flop synchronised
//  pll_reset_req  in   1  single-cycle request to restart the sequence
//  pll_powerdown  out  1  PLL power-down to interconnect, registered
//  mcgb_rst       out  1  master CGB reset to interconnect, registered
//  pll_ready      out  1  PLL locked, qualified, and CGB out of reset
//  timeout_err    out  1  sticky: lock timeout occurred since reset
//  lol_count      out  8  loss-of-lock events seen in READY; saturates at 255
// BEHAVIOUR
//  - Reset values: state=PWRDN, cnt=0, pll_powerdown=1, mcgb_rst=1, pll_ready=0,
//    timeout_err=0, lol_count=0, sync flops=0.
//  - lock_s is pll_locked after the 2-flop synchroniser; it lags the pin by 2 cycles.
//  - All outputs are registered and decoded from the next state, so they change on the
//    same edge as the state transition.
//  - PWRDN: pll_powerdown=1, mcgb_rst=1.
//    After reset release, pll_powerdown stays high for exactly PWRDN_CYCLES cycles,
//    then the FSM moves to WAIT_LOCK with cnt=0.
//  - WAIT_LOCK: pll_powerdown=0, mcgb_rst=1.
//    - cnt counts every cycle and is not cleared by lock glitches.
//    - A separate stable counter increments while lock_s=1 and clears to 0 when lock_s=0.
//    - Stable count reaching LOCK_STABLE_CYCLES -> MCGB.
//    - Otherwise, cnt reaching LOCK_TIMEOUT_CYCLES -> FAULT.
//    - If both conditions hit on the same cycle, lock wins.
//  - MCGB: pll_powerdown=0, mcgb_rst=1 for MCGB_RST_CYCLES cycles, then READY.
//    If lock_s drops during MCGB, go to PWRDN; lol_count does not change.
//  - READY: pll_powerdown=0, mcgb_rst=0, pll_ready=1.
//    If lock_s=0, go to PWRDN; pll_ready falls on the next edge; lol_count +1, saturating.
//  - pll_reset_req=1:
//    - In any state other than PWRDN: go to PWRDN, cnt=0.
//    - In PWRDN: restart the PWRDN count.
//    - Simultaneous with loss of lock in READY: one restart, lol_count +1.
//  - FAULT: pll_powerdown=1, mcgb_rst=1, pll_ready=0, timeout_err set (sticky until reset).
//  - reset asserted in any state: all reset values take effect on the next edge.
//    A sequence in progress is abandoned.
//  - Counters never wrap: each compares with == against its limit and stops there.
// CONFIGURATION
//  PLL_SEQ_AUTO_RETRY_EN defined:
//   - FAULT lasts exactly 1 cycle, then the FSM enters PWRDN with cnt=0 and retries indefinitely.
//   - timeout_err stays sticky.
//  PLL_SEQ_AUTO_RETRY_EN undefined:
//   - FAULT is held until reset, or until pll_reset_req, which moves the FSM to PWRDN.
//   - timeout_err stays set in both cases.
// TESTING
//  (Bench parameters: PWRDN=8, STABLE=4, TIMEOUT=32, MCGB=3.)
//  1. Release reset; pll_locked=1 constant from cycle 0.
//     -> pll_powerdown high for 8 cycles; pll_ready rises 4+3 cycles after WAIT_LOCK entry
//        (plus 2 sync cycles if lock_s not yet high); mcgb_rst falls with pll_ready.
//  2. In WAIT_LOCK, toggle pll_locked as 1,1,1,0 repeatedly.
//     -> never qualifies; FAULT at cnt=32; timeout_err=1, pll_powerdown=1.
//     -> With macro: re-enters PWRDN 1 cycle later. Without: holds FAULT.
//  3. In READY, drop pll_locked for 1 cycle.
//     -> 2 cycles later pll_ready=0, pll_powerdown=1, lol_count=1.
//     -> Full resequence to READY once lock returns.
//  4. Force 256 loss-of-lock cycles from READY -> lol_count saturates at 255.
//  5. pll_reset_req in MCGB -> PWRDN, pll_powerdown=1 for a full 8 cycles.
//     pll_reset_req at PWRDN cycle 5 -> powerdown lasts 5+8 cycles.
//  6. Assert reset mid-WAIT_LOCK with timeout_err=1 -> next edge: all outputs at reset values.

Source files
------------

// File: rtl/q_sys_pll_reset_sequencer_if.sv
// PLL status interconnect request side: power-down and master-CGB reset out, raw lock back.
interface q_sys_pll_reset_sequencer_if;
    logic pll_powerdown;
    logic mcgb_rst;
    logic pll_locked;

    modport master (
        output pll_powerdown,
        output mcgb_rst,
        input  pll_locked
    );

    modport slave (
        input  pll_powerdown,
        input  mcgb_rst,
        output pll_locked
    );
endinterface

// File: rtl/q_sys_pll_reset_sequencer.sv
// PLL power-down / lock qualification / master-CGB reset sequencer with loss-of-lock counting.
// Optional PLL_SEQ_AUTO_RETRY_EN: FAULT retries after one cycle instead of waiting for a request.
module q_sys_pll_reset_sequencer #(
    parameter int PWRDN_CYCLES        = 1000,
    parameter int LOCK_STABLE_CYCLES  = 500,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int MCGB_RST_CYCLES     = 100,
    parameter int CNT_W               = 20
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         pll_reset_req_i,
    q_sys_pll_reset_sequencer_if.master  pll_if,
    output logic                         pll_ready_o,
    output logic                         timeout_err_o,
    output logic [7:0]                   lol_count_o
);

    localparam logic [2:0] S_PWRDN = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_MCGB  = 3'd2;
    localparam logic [2:0] S_READY = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [CNT_W-1:0] PWRDN_LAST   = CNT_W'(PWRDN_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MCGB_LAST    = CNT_W'(MCGB_RST_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stab_q, stab_d;
    logic [7:0]       lol_q, lol_d;
    logic             sync1_q, sync2_q;
    logic             pd_q, pd_d;
    logic             mcgb_q, mcgb_d;
    logic             rdy_q, rdy_d;
    logic             terr_q, terr_d;
    logic             lock_s;

    assign lock_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stab_d  = '0;
        lol_d   = lol_q;
        unique case (state_q)
            S_PWRDN: begin
                if (pll_reset_req_i) begin
                    cnt_d = '0;
                end else if (cnt_q == PWRDN_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                // Lock qualification takes priority over a coincident timeout.
                if (pll_reset_req_i) begin
                    state_d = S_PWRDN;
                    cnt_d   = '0;
                end else if (lock_s && stab_q == STABLE_LAST) begin
                    state_d = S_MCGB;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_FAULT;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    stab_d = lock_s ? stab_q + 1'b1 : '0;
                end
            end
            S_MCGB: begin
                if (pll_reset_req_i || !lock_s) begin
                    state_d = S_PWRDN;
                    cnt_d   = '0;
                end else if (cnt_q == MCGB_LAST) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READY: begin
                if (pll_reset_req_i || !lock_s) begin
                    state_d = S_PWRDN;
                    cnt_d   = '0;
                end
                if (!lock_s && lol_q != 8'hFF) begin
                    lol_d = lol_q + 8'd1;
                end
            end
            S_FAULT: begin
`ifdef PLL_SEQ_AUTO_RETRY_EN
                state_d = S_PWRDN;
                cnt_d   = '0;
`else
                if (pll_reset_req_i) begin
                    state_d = S_PWRDN;
                    cnt_d   = '0;
                end
`endif
            end
            default: begin
                state_d = S_PWRDN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the transition edge.
    always_comb begin
        pd_d   = (state_d == S_PWRDN) || (state_d == S_FAULT);
        mcgb_d = (state_d != S_READY);
        rdy_d  = (state_d == S_READY);
        terr_d = terr_q || (state_d == S_FAULT);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_PWRDN;
            cnt_q   <= '0;
            stab_q  <= '0;
            lol_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            pd_q    <= 1'b1;
            mcgb_q  <= 1'b1;
            rdy_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stab_q  <= stab_d;
            lol_q   <= lol_d;
            sync1_q <= pll_if.pll_locked;
            sync2_q <= sync1_q;
            pd_q    <= pd_d;
            mcgb_q  <= mcgb_d;
            rdy_q   <= rdy_d;
            terr_q  <= terr_d;
        end
    end

    assign pll_if.pll_powerdown = pd_q;
    assign pll_if.mcgb_rst      = mcgb_q;
    assign pll_ready_o          = rdy_q;
    assign timeout_err_o        = terr_q;
    assign lol_count_o          = lol_q;

endmodule
